// File: rtl/fxp_arb_pkg.sv
// ============================================================================
// Module   : fxp_arb_pkg
// Purpose  : Shared helpers for the fixed-point width arbiter: id width and
//            saturation bit patterns.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fxp_arb_pkg;

  localparam int c_pat_w = 64;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [c_pat_w-1:0] max_pos(input int w);
    return (c_pat_w'(1) << (w - 1)) - c_pat_w'(1);
  endfunction

  function automatic logic [c_pat_w-1:0] min_neg(input int w);
    return c_pat_w'(1) << (w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fxp_rr_arbiter.sv
// ============================================================================
// Module   : fxp_rr_arbiter
// Purpose  : Round-robin arbiter; grants the first request at or above ptr,
//            wrapping, producing a one-hot grant and its encoded index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fxp_rr_arbiter
  import fxp_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [id_w(N_REQ)-1:0]  ptr,
  input  logic                    en,
  output logic [N_REQ-1:0]        grant,
  output logic [id_w(N_REQ)-1:0]  idx
);

  localparam int c_id_w = id_w(N_REQ);

  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = c_id_w'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fxp_width_arbiter.sv
// ============================================================================
// Module   : fxp_width_arbiter
// Purpose  : Round-robin shares one fixed-point requantizer among N_REQ
//            requesters onto a registered, tagged valid/ready stream.
//            Define FXP_ARB_OVF_CNT_EN for per-requester overflow counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fxp_width_arbiter
  import fxp_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int IN_INT   = 8,
  parameter int IN_FRAC  = 8,
  parameter int OUT_INT  = 8,
  parameter int OUT_FRAC = 8,
  parameter int ROUND    = 1,
  parameter int CNT_W    = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ*(IN_INT+IN_FRAC)-1:0]   in_data,
  input  logic [N_REQ-1:0]                    in_valid,
  output logic [N_REQ-1:0]                    in_ready,
  output logic [OUT_INT+OUT_FRAC-1:0]         out_data,
  output logic [id_w(N_REQ)-1:0]              out_id,
  output logic                                out_ovf,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_REQ*CNT_W-1:0]              ovf_cnt,
  input  logic                                ovf_cnt_clr
);

  localparam int c_id_w    = id_w(N_REQ);
  localparam int c_in_w    = IN_INT + IN_FRAC;
  localparam int c_out_w   = OUT_INT + OUT_FRAC;
  localparam int c_max_f   = (IN_FRAC > OUT_FRAC) ? IN_FRAC : OUT_FRAC;
  localparam int c_max_i   = (IN_INT > OUT_INT) ? IN_INT : OUT_INT;
  localparam int c_wk      = c_max_i + c_max_f + 2;
  localparam int c_drop    = (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
  localparam int c_pad     = (OUT_FRAC > IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
  localparam int c_rbit    = (c_drop > 0) ? c_drop - 1 : 0;
  localparam int c_lim_int = (IN_INT < OUT_INT) ? IN_INT : OUT_INT;

  // Rounding is suppressed at the largest value representable in both formats,
  // so rounding alone never causes an overflow.
  localparam logic signed [c_wk-1:0]  c_lim_max = c_wk'(max_pos(c_lim_int + OUT_FRAC));
  localparam logic signed [c_wk-1:0]  c_sat_max = c_wk'(max_pos(c_out_w));
  localparam logic [c_out_w-1:0]      c_neg_pat = c_out_w'(min_neg(c_out_w));
  localparam logic signed [c_wk-1:0]  c_sat_min = {{(c_wk - c_out_w){1'b1}}, c_neg_pat};

  // Returns {ovf, data}.
  function automatic logic [c_out_w:0] requant(input logic [c_in_w-1:0] x);
    logic signed [c_wk-1:0] v;
    logic                   rbit;
    v    = {{(c_wk - c_in_w){x[c_in_w-1]}}, x};
    rbit = 1'b0;
    if (c_drop > 0) begin
      rbit = v[c_rbit];
      v    = v >>> c_drop;
    end else begin
      v = v <<< c_pad;
    end
    if ((ROUND != 0) && rbit && (v != c_lim_max)) v = v + c_wk'(1);
    if (v > c_sat_max) return {1'b1, c_sat_max[c_out_w-1:0]};
    if (v < c_sat_min) return {1'b1, c_neg_pat};
    return {1'b0, v[c_out_w-1:0]};
  endfunction

  logic [N_REQ-1:0]    w_grant;
  logic [c_id_w-1:0]   w_idx;
  logic [c_id_w-1:0]   w_ptr_nxt;
  logic [c_in_w-1:0]   w_sel;
  logic [c_out_w:0]    w_conv;
  logic                w_free;
  logic                w_xfer;

  logic                r_out_valid;
  logic [c_out_w-1:0]  r_out_data;
  logic [c_id_w-1:0]   r_out_id;
  logic                r_out_ovf;
  logic [c_id_w-1:0]   r_ptr;

  assign w_free = !r_out_valid || out_ready;

  fxp_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .en    (w_free && rst_n),
    .grant (w_grant),
    .idx   (w_idx)
  );

  assign in_ready  = w_grant;
  assign w_xfer    = |w_grant;
  assign w_sel     = in_data[w_idx*c_in_w +: c_in_w];
  assign w_conv    = requant(w_sel);
  assign w_ptr_nxt = (w_idx == c_id_w'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_ovf   <= 1'b0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_conv[c_out_w-1:0];
      r_out_id    <= w_idx;
      r_out_ovf   <= w_conv[c_out_w];
      r_ptr       <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_ovf   = r_out_ovf;

`ifdef FXP_ARB_OVF_CNT_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ovf_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (ovf_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_grant[gi] && w_conv[c_out_w] && !(&r_cnt)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign ovf_cnt[gi*CNT_W +: CNT_W] = r_cnt;
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = ovf_cnt_clr;
  assign ovf_cnt      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fxp_width_arbiter.sv
// ============================================================================
// Module   : tb_fxp_width_arbiter
// Purpose  : Self-checking bench for fxp_width_arbiter, Q8.8 -> Q4.4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fxp_width_arbiter;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int OW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*IW-1:0] in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready, in_ready_t;
  logic [OW-1:0]   out_data, out_data_t;
  logic [1:0]      out_id, out_id_t;
  logic            out_ovf, out_ovf_t, out_valid, out_valid_t;
  logic            out_ready = 1'b1;
  logic [N*2-1:0]  ovf_cnt, ovf_cnt_t;
  logic            ovf_cnt_clr = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fxp_width_arbiter #(
    .N_REQ(N), .IN_INT(8), .IN_FRAC(8), .OUT_INT(4), .OUT_FRAC(4), .ROUND(1), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_id(out_id), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_cnt(ovf_cnt), .ovf_cnt_clr(ovf_cnt_clr)
  );

  fxp_width_arbiter #(
    .N_REQ(N), .IN_INT(8), .IN_FRAC(8), .OUT_INT(4), .OUT_FRAC(4), .ROUND(0), .CNT_W(2)
  ) dut_t (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_t),
    .out_data(out_data_t), .out_id(out_id_t), .out_ovf(out_ovf_t), .out_valid(out_valid_t),
    .out_ready(out_ready), .ovf_cnt(ovf_cnt_t), .ovf_cnt_clr(ovf_cnt_clr)
  );

  // Q8.8 -> Q4.4 reference; returns {ovf, data}.
  function automatic logic [8:0] model(input logic [15:0] x, input bit rnd);
    int t;
    t = int'($signed(x)) >>> 4;
    if (rnd && x[3] && t != 127) t = t + 1;
    if (t > 127)  return {1'b1, 8'h7F};
    if (t < -128) return {1'b1, 8'h80};
    return {1'b0, t[7:0]};
  endfunction

  // One clock: retire/record handshakes at the negedge, return at posedge+1.
  task automatic step();
    exp_t       e;
    logic [8:0] m;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got data=%h id=%0d with nothing expected", out_data, out_id);
      end else begin
        e = sb.pop_front();
        if ({out_data, out_id, out_ovf} !== e) begin
          bad++;
          $display("FAIL sb_output: got data=%h id=%0d ovf=%b, want data=%h id=%0d ovf=%b",
                   out_data, out_id, out_ovf, e.data, e.id, e.ovf);
        end
      end
    end
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          m = model(in_data[i*IW +: IW], 1'b1);
          sb.push_back({m[7:0], 2'(i), m[8]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input logic [15:0] d);
    int n;
    n = 0;
    in_data[r*IW +: IW] = d;
    in_valid[r] = 1'b1;
    while (!in_ready[r] && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL send_timeout: requester %0d never granted, in_ready=%b", r, in_ready);
    end
    step();
    in_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    ovf_cnt_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    in_valid = '1;
    in_data = {4{16'h1000}};
    #1;
    total++;
    if (in_ready !== 4'b0) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_ovf, out_id, out_data} !== 12'h0) begin
      bad++;
      $display("FAIL reset_out: got valid=%b ovf=%b id=%0d data=%h want all 0",
               out_valid, out_ovf, out_id, out_data);
    end
    total++;
    if (ovf_cnt !== 8'h0) begin
      bad++;
      $display("FAIL reset_cnt: got %h want 00", ovf_cnt);
    end
    in_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_convert();
    logic [15:0] vin[4];
    logic [7:0]  vd[4];
    logic        vo[4];
    vin = '{16'h0118, 16'h1000, 16'hF000, 16'h07F8};
    vd  = '{8'h12, 8'h7F, 8'h80, 8'h7F};
    vo  = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      send(0, vin[k]);
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== vd[k] || out_ovf !== vo[k]) begin
        bad++;
        $display("FAIL convert_%0d: got valid=%b id=%0d data=%h ovf=%b want 1 0 %h %b",
                 k, out_valid, out_id, out_data, out_ovf, vd[k], vo[k]);
      end
    end
    step();
  endtask

  task automatic test_truncate();
    logic [15:0] x;
    logic [8:0]  m;
    send(0, 16'h0118);
    total++;
    if (out_valid_t !== 1'b1 || out_data_t !== 8'h11 || out_ovf_t !== 1'b0) begin
      bad++;
      $display("FAIL truncate_fixed: got valid=%b data=%h ovf=%b want 1 11 0",
               out_valid_t, out_data_t, out_ovf_t);
    end
    for (int k = 0; k < 4; k++) begin
      x = 16'($urandom);
      m = model(x, 1'b0);
      send(1, x);
      total++;
      if (out_data_t !== m[7:0] || out_ovf_t !== m[8]) begin
        bad++;
        $display("FAIL truncate_rand: in=%h got data=%h ovf=%b want %h %b",
                 x, out_data_t, out_ovf_t, m[7:0], m[8]);
      end
    end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    in_data = {$urandom, $urandom};
    in_valid = '1;
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'(c % 4)) begin
        bad++;
        $display("FAIL rr_seq_%0d: got valid=%b id=%0d want 1 %0d", c, out_valid, out_id, c % 4);
      end
      in_data = {$urandom, $urandom};
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_stall();
    do_reset();
    in_data = {$urandom, $urandom};
    in_valid = '1;
    step();
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (in_ready !== 4'b0 || out_valid !== 1'b1 || out_id !== 2'd1 ||
          sb.size() == 0 || out_data !== sb[0].data) begin
        bad++;
        $display("FAIL stall_%0d: got in_ready=%b valid=%b id=%0d data=%h want 0000 1 1 held",
                 c, in_ready, out_valid, out_id, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin
      bad++;
      $display("FAIL stall_resume_grant: got %b want 0100", in_ready);
    end
    step();
    total++;
    if (out_id !== 2'd2) begin
      bad++;
      $display("FAIL stall_resume_id: got %0d want 2", out_id);
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_counter();
    do_reset();
    send(2, 16'h1000);
    send(2, 16'h1000);
`ifdef FXP_ARB_OVF_CNT_EN
    total++;
    if (ovf_cnt !== 8'b00_10_00_00) begin
      bad++;
      $display("FAIL cnt_two: got %b want 00100000", ovf_cnt);
    end
`endif
    for (int k = 0; k < 3; k++) send(2, 16'h1000);
    step();
`ifdef FXP_ARB_OVF_CNT_EN
    total++;
    if (ovf_cnt !== 8'b00_11_00_00) begin
      bad++;
      $display("FAIL cnt_sat: got %b want 00110000", ovf_cnt);
    end
`else
    total++;
    if (ovf_cnt !== 8'h0) begin
      bad++;
      $display("FAIL cnt_disabled: got %b want 00000000", ovf_cnt);
    end
`endif
    ovf_cnt_clr = 1'b1;
    send(2, 16'h1000);
    ovf_cnt_clr = 1'b0;
    total++;
    if (ovf_cnt !== 8'h0) begin
      bad++;
      $display("FAIL cnt_clr: got %b want 00000000", ovf_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_data = {4{16'h1000}};
    in_valid = '1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0 || ovf_cnt !== 8'h0) begin
      bad++;
      $display("FAIL reset_mid: got valid=%b in_ready=%b cnt=%b want 0 0000 00000000",
               out_valid, in_ready, ovf_cnt);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_mid_ptr: got in_ready=%b want 0001", in_ready);
    end
    in_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_convert();
    test_truncate();
    test_round_robin();
    test_stall();
    test_counter();
    test_reset_mid();
    in_valid = '0;
    out_ready = 1'b1;
    step();
    step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expected samples never appeared", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
